tlpcie_fsm: RTL and testbench

Control state machine for the four-lane transaction-layer FIFO bank. It sequences reset and initialization, and watches the status flags of FIFOs 0–3 (pause, continue, empty, error, full). It drives registered per-lane pause/continue commands, a per-lane error/full report and a global idle indication to the TL data path.

---
 rtl/tlpcie_fsm.sv | 118 +++++++++++
 tb/tb_tlpcie_fsm.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlpcie_fsm.sv
// Control FSM for the four-lane TL FIFO bank: sequences reset/init and turns FIFO flags into lane commands.
// Latency: every output is registered, one cycle after the state/flags that produced it; reset clears them at once.
// Backpressure: drives pause/continue per lane; FSM_ERROR_LATCH_EN makes error_full sticky and ERROR exit-by-init only.
module tlpcie_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       FIFOpause0,
    input  logic       FIFOpause1,
    input  logic       FIFOpause2,
    input  logic       FIFOpause3,
    input  logic       FIFOcontinue0,
    input  logic       FIFOcontinue1,
    input  logic       FIFOcontinue2,
    input  logic       FIFOcontinue3,
    input  logic       FIFOempty0,
    input  logic       FIFOempty1,
    input  logic       FIFOempty2,
    input  logic       FIFOempty3,
    input  logic       FIFOerror0,
    input  logic       FIFOerror1,
    input  logic       FIFOerror2,
    input  logic       FIFOerror3,
    input  logic       FIFOfull0,
    input  logic       FIFOfull1,
    input  logic       FIFOfull2,
    input  logic       FIFOfull3,
    output logic [3:0] error_full,
    output logic [3:0] pause,
    output logic [3:0] continue_cmd,
    output logic       idle
);

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] error_full_q, error_full_d;
    logic [3:0] pause_q, pause_d;
    logic [3:0] continue_q, continue_d;
    logic       idle_q, idle_d;

    logic [3:0] fifo_pause, fifo_cont, fifo_empty, fifo_bad;
    logic       any_bad, all_empty;

    assign fifo_pause = {FIFOpause3, FIFOpause2, FIFOpause1, FIFOpause0};
    assign fifo_cont  = {FIFOcontinue3, FIFOcontinue2, FIFOcontinue1, FIFOcontinue0};
    assign fifo_empty = {FIFOempty3, FIFOempty2, FIFOempty1, FIFOempty0};
    assign fifo_bad   = {FIFOerror3 | FIFOfull3, FIFOerror2 | FIFOfull2,
                         FIFOerror1 | FIFOfull1, FIFOerror0 | FIFOfull0};
    assign any_bad    = |fifo_bad;
    assign all_empty  = &fifo_empty;

    // Transition priority: init, then error/full, then empty/non-empty.
    always_comb begin
        state_d      = state_q;
        error_full_d = 4'b0000;
        pause_d      = 4'b0000;
        continue_d   = 4'b0000;
        idle_d       = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT:  state_d = init ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                idle_d = all_empty;
                if (init)            state_d = ST_INIT;
                else if (any_bad)    state_d = ST_ERROR;
                else if (!all_empty) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                pause_d    = fifo_pause;
                continue_d = fifo_cont & ~fifo_pause;
                if (init)           state_d = ST_INIT;
                else if (any_bad)   state_d = ST_ERROR;
                else if (all_empty) state_d = ST_IDLE;
            end
            ST_ERROR: begin
                pause_d = 4'b1111;
`ifdef FSM_ERROR_LATCH_EN
                error_full_d = error_full_q | fifo_bad;
                if (init) state_d = ST_INIT;
`else
                error_full_d = fifo_bad;
                if (init)          state_d = ST_INIT;
                else if (!any_bad) state_d = all_empty ? ST_IDLE : ST_ACTIVE;
`endif
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RESET;
            error_full_q <= 4'b0000;
            pause_q      <= 4'b0000;
            continue_q   <= 4'b0000;
            idle_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            error_full_q <= error_full_d;
            pause_q      <= pause_d;
            continue_q   <= continue_d;
            idle_q       <= idle_d;
        end
    end

    assign error_full   = error_full_q;
    assign pause        = pause_q;
    assign continue_cmd = continue_q;
    assign idle         = idle_q;

endmodule

// File: tb/tb_tlpcie_fsm.sv
// Bench for tlpcie_fsm: directed scenarios plus randomized flags against a rule-level reference model.
module tb_tlpcie_fsm;

    logic       clk = 1'b0;
    logic       reset, init;
    logic [3:0] p, c, e, er, f;
    logic [3:0] error_full, pause, continue_cmd;
    logic       idle;

    int checks = 0;
    int errors = 0;

    localparam int M_RST = 0, M_INIT = 1, M_IDLE = 2, M_ACT = 3, M_ERR = 4;
`ifdef FSM_ERROR_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    int         m_st;
    logic [3:0] x_ef, x_pa, x_co;
    logic       x_idle;

    always #5 clk = ~clk;

    tlpcie_fsm dut (
        .clk(clk), .reset(reset), .init(init),
        .FIFOpause0(p[0]), .FIFOpause1(p[1]), .FIFOpause2(p[2]), .FIFOpause3(p[3]),
        .FIFOcontinue0(c[0]), .FIFOcontinue1(c[1]), .FIFOcontinue2(c[2]), .FIFOcontinue3(c[3]),
        .FIFOempty0(e[0]), .FIFOempty1(e[1]), .FIFOempty2(e[2]), .FIFOempty3(e[3]),
        .FIFOerror0(er[0]), .FIFOerror1(er[1]), .FIFOerror2(er[2]), .FIFOerror3(er[3]),
        .FIFOfull0(f[0]), .FIFOfull1(f[1]), .FIFOfull2(f[2]), .FIFOfull3(f[3]),
        .error_full(error_full), .pause(pause), .continue_cmd(continue_cmd), .idle(idle)
    );

    // Reference model: outputs follow the mode held before the edge; mode then moves by the rules.
    task automatic tick();
        logic bad, all_e;
        @(posedge clk);
        if (reset) begin
            bad   = |(er | f);
            all_e = &e;
            x_pa   = (m_st == M_ACT) ? p : (m_st == M_ERR) ? 4'b1111 : 4'b0000;
            x_co   = (m_st == M_ACT) ? (c & ~p) : 4'b0000;
            x_idle = (m_st == M_IDLE) && all_e;
            if (m_st == M_ERR) x_ef = LATCH ? (x_ef | er | f) : (er | f);
            else               x_ef = 4'b0000;
            if (m_st == M_RST)                   m_st = M_INIT;
            else if (init)                       m_st = M_INIT;
            else if (m_st == M_INIT)             m_st = M_IDLE;
            else if (m_st == M_ERR && LATCH)     m_st = M_ERR;
            else if (bad)                        m_st = M_ERR;
            else                                 m_st = all_e ? M_IDLE : M_ACT;
        end
        #1;
    endtask

    task automatic model_reset();
        m_st = M_RST; x_ef = 0; x_pa = 0; x_co = 0; x_idle = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b1; e = 4'hF; p = 0; c = 0; er = 0; f = 0;
        model_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({error_full, pause, continue_cmd, idle} !== 13'd0) begin
            errors++;
            $display("FAIL reset_immediate: got ef=%b pa=%b co=%b idle=%b, want all 0", error_full, pause, continue_cmd, idle);
        end
        repeat (2) begin
            tick();
            checks++;
            if ({error_full, pause, continue_cmd, idle} !== 13'd0) begin
                errors++;
                $display("FAIL reset_held: got ef=%b pa=%b co=%b idle=%b, want all 0", error_full, pause, continue_cmd, idle);
            end
        end
        reset = 1'b1;
        #4 init = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({error_full, pause, continue_cmd, idle} !== {x_ef, x_pa, x_co, x_idle}) begin
                errors++;
                $display("FAIL reset_release cyc%0d: got ef=%b pa=%b co=%b idle=%b, want ef=%b pa=%b co=%b idle=%b",
                         i, error_full, pause, continue_cmd, idle, x_ef, x_pa, x_co, x_idle);
            end
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_up: got idle=%b, want 1", idle);
        end
    endtask

    task automatic test_active();
        e = 4'b1011; p = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({error_full, pause, continue_cmd, idle} !== {x_ef, x_pa, x_co, x_idle}) begin
                errors++;
                $display("FAIL active_enter cyc%0d: got ef=%b pa=%b co=%b idle=%b, want ef=%b pa=%b co=%b idle=%b",
                         i, error_full, pause, continue_cmd, idle, x_ef, x_pa, x_co, x_idle);
            end
        end
        checks++;
        if (pause !== 4'b0100 || idle !== 1'b0) begin
            errors++;
            $display("FAIL active_pause2: got pause=%b idle=%b, want pause=0100 idle=0", pause, idle);
        end
        p = 4'b0010; c = 4'b0011;
        tick();
        checks++;
        if (pause !== 4'b0010 || continue_cmd !== 4'b0001) begin
            errors++;
            $display("FAIL active_pause_wins: got pause=%b cont=%b, want pause=0010 cont=0001", pause, continue_cmd);
        end
    endtask

    task automatic test_error_full();
        f = 4'b1000;
        for (int i = 0; i < 2; i++) tick();
        checks++;
        if (error_full !== 4'b1000 || pause !== 4'b1111 || continue_cmd !== 4'b0000) begin
            errors++;
            $display("FAIL error_full3: got ef=%b pa=%b co=%b, want ef=1000 pa=1111 co=0000", error_full, pause, continue_cmd);
        end
        f = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({error_full, pause, continue_cmd, idle} !== {x_ef, x_pa, x_co, x_idle}) begin
                errors++;
                $display("FAIL error_clear cyc%0d: got ef=%b pa=%b co=%b idle=%b, want ef=%b pa=%b co=%b idle=%b",
                         i, error_full, pause, continue_cmd, idle, x_ef, x_pa, x_co, x_idle);
            end
        end
        checks++;
        if (LATCH ? (error_full !== 4'b1000 || pause !== 4'b1111) : (error_full !== 4'b0000 || pause !== p)) begin
            errors++;
            $display("FAIL error_after_clear: got ef=%b pa=%b, want latch=%0d behaviour", error_full, pause, LATCH);
        end
        init = 1'b1;
        tick();
        init = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({error_full, pause, continue_cmd, idle} !== {x_ef, x_pa, x_co, x_idle}) begin
                errors++;
                $display("FAIL error_reinit cyc%0d: got ef=%b pa=%b co=%b idle=%b, want ef=%b pa=%b co=%b idle=%b",
                         i, error_full, pause, continue_cmd, idle, x_ef, x_pa, x_co, x_idle);
            end
        end
    endtask

    task automatic test_multi_error();
        er = 4'b0101;
        for (int i = 0; i < 2; i++) tick();
        checks++;
        if (error_full !== 4'b0101) begin
            errors++;
            $display("FAIL multi_error: got ef=%b, want 0101", error_full);
        end
        er = 4'b0000; init = 1'b1;
        tick();
        init = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_async_reset_mid();
        e = 4'b0110; p = 0; c = 4'b1001;
        repeat (2) tick();
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({error_full, pause, continue_cmd, idle} !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset_immediate: got ef=%b pa=%b co=%b idle=%b, want all 0", error_full, pause, continue_cmd, idle);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({error_full, pause, continue_cmd, idle} !== {x_ef, x_pa, x_co, x_idle}) begin
                errors++;
                $display("FAIL mid_reset_release cyc%0d: got ef=%b pa=%b co=%b idle=%b, want ef=%b pa=%b co=%b idle=%b",
                         i, error_full, pause, continue_cmd, idle, x_ef, x_pa, x_co, x_idle);
            end
        end
        checks++;
        if (continue_cmd !== 4'b1001) begin
            errors++;
            $display("FAIL mid_reset_resume: got cont=%b, want 1001", continue_cmd);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            e    = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            p    = 4'($urandom);
            c    = 4'($urandom);
            er   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            f    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            init = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 59) == 0) begin
                #2 reset = 1'b0;
                model_reset();
                #1;
                checks++;
                if ({error_full, pause, continue_cmd, idle} !== 13'd0) begin
                    errors++;
                    $display("FAIL rand_reset cyc%0d: got ef=%b pa=%b co=%b idle=%b, want all 0", i, error_full, pause, continue_cmd, idle);
                end
                #1 reset = 1'b1;
            end
            tick();
            checks++;
            if ({error_full, pause, continue_cmd, idle} !== {x_ef, x_pa, x_co, x_idle}) begin
                errors++;
                $display("FAIL rand cyc%0d: got ef=%b pa=%b co=%b idle=%b, want ef=%b pa=%b co=%b idle=%b",
                         i, error_full, pause, continue_cmd, idle, x_ef, x_pa, x_co, x_idle);
            end
            checks++;
            if ((pause & continue_cmd) !== 4'b0000) begin
                errors++;
                $display("FAIL rand_exclusive cyc%0d: got pause=%b cont=%b, want no overlap", i, pause, continue_cmd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_active();
        test_error_full();
        test_active();
        test_multi_error();
        test_async_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
